mbgd_dot_prod_reduce: RTL

MBGD_DOT_PROD_REDUCE -- requirements
Module: mbgd_dot_prod_reduce

---
 rtl/mbgd_dot_prod_reduce.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mbgd_dot_prod_reduce.sv
// Mini-batch GD dot-product reducer: N-lane adder tree plus a beat accumulator.
// Folds multi-beat vectors of lane products into one sum, with beat count and overflow flag.
module mbgd_dot_prod_reduce #(
    parameter int N     = 8,
    parameter int N_bit = 3,
    parameter int DW    = 8,
    parameter int BW    = 4,
    localparam int PW    = 2 * DW + N_bit,
    localparam int TW    = PW + N_bit,
    localparam int ACC_W = PW + N_bit + BW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [N*PW-1:0]   in_prod,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BW:0]       out_beats,
    output logic              out_ovf
);

    typedef enum logic {EMPTY, PARTIAL} state_t;

    localparam logic [BW:0] MAXB = {1'b1, {BW{1'b0}}};

    logic             en;
    logic [TW-1:0]    node [N_bit+1][N];
    logic [N_bit-1:0] vld_q;
    logic [N_bit-1:0] lst_q;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [BW:0]      beats_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [BW:0]      out_beats_q;
    logic             out_ovf_q;

    logic [ACC_W-1:0] tree_sum;
    logic [ACC_W-1:0] sum_d;
    logic [BW:0]      beats_d;
    logic             ovf_d;
    logic             sat;
    logic             tv;
    logic             tl;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = reset && en;

    for (genvar j = 0; j < N; j++) begin : g_in
        assign node[0][j] = TW'(in_prod[j*PW +: PW]);
    end

    for (genvar k = 1; k <= N_bit; k++) begin : g_stg
        for (genvar j = 0; j < N; j++) begin : g_lane
            if (j < (N >> k)) begin : g_add
                logic [PW+k-1:0] sum_q;
                // Pairwise add of the previous level; one bit of growth per level.
                always_ff @(posedge clk) begin
                    if (!reset)
                        sum_q <= '0;
                    else if (en)
                        sum_q <= (PW+k)'(node[k-1][2*j] + node[k-1][2*j+1]);
                end
                assign node[k][j] = TW'(sum_q);
            end else begin : g_nil
                assign node[k][j] = '0;
            end
        end
    end

    // Valid/last tags travel alongside the tree; bubbles enter as valid=0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (en) begin
            vld_q <= (vld_q << 1) | N_bit'(in_valid && in_ready);
            lst_q <= (lst_q << 1) | N_bit'(in_last);
        end
    end

    assign tv       = vld_q[N_bit-1];
    assign tl       = lst_q[N_bit-1];
    assign tree_sum = ACC_W'(node[N_bit][0]);
    assign sat      = (beats_q == MAXB);
    assign sum_d    = (state_q == EMPTY) ? tree_sum : acc_q + tree_sum;
    assign beats_d  = (state_q == EMPTY) ? (BW+1)'(1)
                    : (sat ? MAXB : beats_q + 1'b1);
    assign ovf_d    = (state_q == PARTIAL) && (ovf_q || sat);

    // Accumulator FSM and registered result; a new result may replace one being taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= 1'b0;
            if (tv) begin
                if (tl) begin
                    out_sum_q   <= sum_d;
                    out_beats_q <= beats_d;
                    out_ovf_q   <= ovf_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    beats_q     <= '0;
                    ovf_q       <= 1'b0;
                    state_q     <= EMPTY;
                end else begin
                    acc_q       <= sum_d;
                    beats_q     <= beats_d;
                    ovf_q       <= ovf_d;
                    state_q     <= PARTIAL;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule
